// File: rtl/i2c_sensor_master_if.sv
// Command handshake and open-drain bus signals of the I2C sensor master.
// The controller/bench side uses the master modport; the engine uses slave.
interface i2c_sensor_master_if;
   logic       start_I2C;
   logic       mode_I2C;
   logic [6:0] sensorAddr_I2C;
   logic [7:0] writeVal_I2C;
   logic [7:0] readVal_I2C;
   logic       dataRdy_I2C;
   logic       ack_err;
   logic       busy;
   logic       scl_oe;
   logic       sda_oe;
   logic       sda_in;

   modport master (
      output start_I2C, mode_I2C, sensorAddr_I2C, writeVal_I2C, sda_in,
      input  readVal_I2C, dataRdy_I2C, ack_err, busy, scl_oe, sda_oe
   );

   modport slave (
      input  start_I2C, mode_I2C, sensorAddr_I2C, writeVal_I2C, sda_in,
      output readVal_I2C, dataRdy_I2C, ack_err, busy, scl_oe, sda_oe
   );
endinterface

// File: rtl/i2c_sensor_master.sv
// Byte-level I2C master: one single-byte write or read per accepted command.
// Every bus phase is a bit slot of four quarters of CLK_DIV cycles each; the
// SCL/SDA enables are registered from the next-state values so they line up
// with the state that owns the current quarter.
module i2c_sensor_master #(
   parameter int CLK_DIV = 4
) (
   input logic                clock,
   input logic                rst,
   i2c_sensor_master_if.slave bus
);
   localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WDATA, S_WDATA_ACK,
      S_RDATA, S_RDATA_NACK, S_STOP, S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [QW-1:0]   qcnt_q, qcnt_d;
   logic [1:0]      qidx_q, qidx_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      tx_q, tx_d;
   logic [7:0]      rx_q, rx_d;
   logic [7:0]      wdata_q, wdata_d;
   logic            mode_q, mode_d;
   logic            ack_err_q, ack_err_d;
   logic [7:0]      rdval_q, rdval_d;
   logic            rdy_q, rdy_d;
   logic            busy_q, busy_d;
   logic            scl_oe_q, scl_oe_d;
   logic            sda_oe_q, sda_oe_d;
   logic            slot_end;
   logic            sample_pt;

   // {scl_oe, sda_oe} for a state/quarter; b is the data bit being sent.
   function automatic logic [1:0] drive(input state_t s, input logic [1:0] qi, input logic b);
      logic [1:0] r;
      r = 2'b00;
      case (s)
         S_START: begin
            if (qi == 2'd2)      r = 2'b01;
            else if (qi == 2'd3) r = 2'b11;
            else                 r = 2'b00;
         end
         S_ADDR, S_WDATA:
            r = {~qi[1], ~b};
         S_ADDR_ACK, S_WDATA_ACK, S_RDATA, S_RDATA_NACK:
            r = {~qi[1], 1'b0};
         S_STOP: begin
            if (qi == 2'd0)      r = 2'b11;
            else if (qi == 2'd1) r = 2'b01;
            else                 r = 2'b00;
         end
         default: r = 2'b00;
      endcase
      return r;
   endfunction

   // Next-state, quarter timing and registered-output computation.
   always_comb begin
      state_d   = state_q;
      qcnt_d    = qcnt_q;
      qidx_d    = qidx_q;
      bit_d     = bit_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      wdata_d   = wdata_q;
      mode_d    = mode_q;
      ack_err_d = ack_err_q;
      rdval_d   = rdval_q;
      slot_end  = 1'b0;
      sample_pt = 1'b0;

      if (state_q != S_IDLE && state_q != S_DONE) begin
         if (qcnt_q == QMAX) begin
            qcnt_d    = '0;
            qidx_d    = qidx_q + 2'd1;
            sample_pt = (qidx_q == 2'd2);
            slot_end  = (qidx_q == 2'd3);
         end else begin
            qcnt_d = qcnt_q + 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (bus.start_I2C) begin
               tx_d      = {bus.sensorAddr_I2C, bus.mode_I2C};
               mode_d    = bus.mode_I2C;
               wdata_d   = bus.writeVal_I2C;
               ack_err_d = 1'b0;
               qcnt_d    = '0;
               qidx_d    = 2'd0;
               state_d   = S_START;
            end
         end
         S_START: begin
            if (slot_end) begin
               bit_d   = 3'd7;
               state_d = S_ADDR;
            end
         end
         S_ADDR, S_WDATA: begin
            if (slot_end) begin
               tx_d = {tx_q[6:0], 1'b0};
               if (bit_q == 3'd0) state_d = (state_q == S_ADDR) ? S_ADDR_ACK : S_WDATA_ACK;
               else               bit_d   = bit_q - 3'd1;
            end
         end
         S_ADDR_ACK: begin
            if (sample_pt && bus.sda_in) ack_err_d = 1'b1;
            if (slot_end) begin
               bit_d = 3'd7;
               if (ack_err_q) begin
                  state_d = S_STOP;
               end else if (mode_q) begin
                  state_d = S_RDATA;
               end else begin
                  tx_d    = wdata_q;
                  state_d = S_WDATA;
               end
            end
         end
         S_WDATA_ACK: begin
            if (sample_pt && bus.sda_in) ack_err_d = 1'b1;
            if (slot_end) state_d = S_STOP;
         end
         S_RDATA: begin
            if (sample_pt) rx_d = {rx_q[6:0], bus.sda_in};
            if (slot_end) begin
               if (bit_q == 3'd0) state_d = S_RDATA_NACK;
               else               bit_d   = bit_q - 3'd1;
            end
         end
         S_RDATA_NACK: begin
            if (slot_end) state_d = S_STOP;
         end
         S_STOP: begin
            // Read data becomes visible together with the completion pulse.
            if (slot_end) begin
               if (mode_q && !ack_err_q) rdval_d = rx_q;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      rdy_d                  = (state_d == S_DONE);
      busy_d                 = (state_d != S_IDLE);
      {scl_oe_d, sda_oe_d}   = drive(state_d, qidx_d, tx_d[7]);
   end

   // Control state and bus enables; reset releases the bus immediately.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         qcnt_q    <= '0;
         qidx_q    <= 2'd0;
         bit_q     <= 3'd0;
         ack_err_q <= 1'b0;
         rdval_q   <= 8'd0;
         rdy_q     <= 1'b0;
         busy_q    <= 1'b0;
         scl_oe_q  <= 1'b0;
         sda_oe_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         qcnt_q    <= qcnt_d;
         qidx_q    <= qidx_d;
         bit_q     <= bit_d;
         ack_err_q <= ack_err_d;
         rdval_q   <= rdval_d;
         rdy_q     <= rdy_d;
         busy_q    <= busy_d;
         scl_oe_q  <= scl_oe_d;
         sda_oe_q  <= sda_oe_d;
      end
   end

   // Shift registers and captured command fields; always written before use.
   always_ff @(posedge clock) begin
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      wdata_q <= wdata_d;
      mode_q  <= mode_d;
   end

   assign bus.readVal_I2C = rdval_q;
   assign bus.dataRdy_I2C = rdy_q;
   assign bus.ack_err     = ack_err_q;
   assign bus.busy        = busy_q;
   assign bus.scl_oe      = scl_oe_q;
   assign bus.sda_oe      = sda_oe_q;
endmodule

// File: tb/tb_i2c_sensor_master.sv
// Bench for i2c_sensor_master: a bus-level responder model decodes START,
// bytes and STOP from the open-drain lines; a scoreboard of expected
// transactions is filled by the stimulus and drained by a monitor.
module tb_i2c_sensor_master;
   localparam int CD = 4;

   logic clock = 1'b0;
   logic rst   = 1'b1;
   int   cyc   = 0;
   int   checks = 0;
   int   errors = 0;

   i2c_sensor_master_if bus();
   i2c_sensor_master #(.CLK_DIV(CD)) dut (.clock(clock), .rst(rst), .bus(bus));

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int         rdy_cyc;
      logic [7:0] addr_byte;
      logic [7:0] wbyte;
      bit         chk_wbyte;
      bit         chk_nack;
      logic       ack_err;
      logic [7:0] rdval;
   } exp_t;
   exp_t sb[$];

   // responder configuration and observations
   logic       slave_pull = 1'b0;
   logic       cfg_ack_addr = 1'b1, cfg_ack_data = 1'b1;
   logic [7:0] cfg_rdata = 8'h00;
   logic [7:0] obs_addr, obs_wbyte, shreg;
   logic       obs_nack;
   int         starts_tot = 0, stops_tot = 0;
   logic [7:0] exp_rdval = 8'h00;

   assign bus.sda_in = ~(bus.sda_oe | slave_pull);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Responder: decodes the wired-AND bus and answers ACK / read data.
   initial begin
      logic scl_n, sda_n, prev_scl, prev_sda, in_txn, is_read, addr_acked;
      int   bit_n, byte_n;
      prev_scl = 1'b1; prev_sda = 1'b1; in_txn = 1'b0; is_read = 1'b0; addr_acked = 1'b0;
      bit_n = 0; byte_n = 0;
      forever begin
         @(negedge clock);
         scl_n = ~bus.scl_oe;
         sda_n = ~(bus.sda_oe | slave_pull);
         if (rst) begin
            in_txn = 1'b0; slave_pull = 1'b0; bit_n = 0; byte_n = 0;
         end else if (prev_scl && scl_n && prev_sda && !sda_n) begin
            starts_tot++;
            in_txn = 1'b1; bit_n = 0; byte_n = 0; slave_pull = 1'b0; addr_acked = 1'b0;
            obs_addr = 'x; obs_wbyte = 'x; obs_nack = 1'b0;
         end else if (prev_scl && scl_n && !prev_sda && sda_n) begin
            stops_tot++;
            in_txn = 1'b0; slave_pull = 1'b0;
         end else if (in_txn && !prev_scl && scl_n) begin
            if (bit_n < 8) begin
               shreg = {shreg[6:0], sda_n};
               bit_n++;
            end else begin
               if (byte_n == 1 && is_read) obs_nack = sda_n;
               bit_n = 0;
               byte_n++;
            end
         end else if (in_txn && prev_scl && !scl_n) begin
            if (bit_n == 8) begin
               if (byte_n == 0) begin
                  obs_addr = shreg; is_read = shreg[0];
                  addr_acked = cfg_ack_addr; slave_pull = cfg_ack_addr;
               end else if (!is_read) begin
                  obs_wbyte = shreg; slave_pull = cfg_ack_data;
               end else begin
                  slave_pull = 1'b0;
               end
            end else if (byte_n == 1 && is_read && addr_acked) begin
               slave_pull = ~cfg_rdata[7 - bit_n];
            end else begin
               slave_pull = 1'b0;
            end
         end
         prev_scl = scl_n;
         prev_sda = sda_n;
      end
   end

   // Monitor: pops the scoreboard on every completion pulse.
   initial begin
      exp_t e;
      logic prev_rdy;
      int   last_st, last_sp;
      prev_rdy = 1'b0; last_st = 0; last_sp = 0;
      forever begin
         @(negedge clock);
         #1;
         if (rst) begin
            last_st = starts_tot; last_sp = stops_tot; prev_rdy = 1'b0;
         end else begin
            if (prev_rdy) begin
               check("rdy_one_cycle", bus.dataRdy_I2C, 0);
               check("busy_after_done", bus.busy, 0);
            end
            if (bus.dataRdy_I2C) begin
               if (sb.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_rdy: pulse at cycle %0d, none expected", cyc);
               end else begin
                  e = sb.pop_front();
                  check("rdy_cycle", cyc, e.rdy_cyc);
                  check("busy_in_done", bus.busy, 1);
                  check("ack_err", bus.ack_err, e.ack_err);
                  check("readVal", bus.readVal_I2C, e.rdval);
                  check("addr_byte", obs_addr, e.addr_byte);
                  if (e.chk_wbyte) check("write_byte", obs_wbyte, e.wbyte);
                  if (e.chk_nack)  check("master_nack", obs_nack, 1);
                  check("start_count", starts_tot - last_st, 1);
                  check("stop_count", stops_tot - last_sp, 1);
               end
               last_st = starts_tot; last_sp = stops_tot;
            end
            prev_rdy = bus.dataRdy_I2C;
         end
      end
   end

   // Issue one command at a negedge; returns at the START q0 negedge.
   task automatic issue(input logic [6:0] addr, input logic mode, input logic [7:0] wbyte,
                        input logic ack_a, input logic ack_d, input logic [7:0] rdata);
      exp_t e;
      cfg_ack_addr = ack_a; cfg_ack_data = ack_d; cfg_rdata = rdata;
      e.addr_byte = {addr, mode};
      e.ack_err   = !ack_a || (!mode && !ack_d);
      if (mode && ack_a) exp_rdval = rdata;
      e.rdval     = exp_rdval;
      e.wbyte     = wbyte;
      e.chk_wbyte = !mode && ack_a;
      e.chk_nack  = mode && ack_a;
      e.rdy_cyc   = cyc + 1 + (ack_a ? 80 * CD : 44 * CD);
      sb.push_back(e);
      bus.start_I2C = 1'b1; bus.mode_I2C = mode; bus.sensorAddr_I2C = addr; bus.writeVal_I2C = wbyte;
      @(negedge clock);
      bus.start_I2C = 1'b0;
      bus.mode_I2C = 1'($urandom); bus.sensorAddr_I2C = 7'($urandom); bus.writeVal_I2C = 8'($urandom);
   endtask

   task automatic wait_rdy();
      int n;
      n = 0;
      while (!bus.dataRdy_I2C && n < 200 * CD) begin
         @(negedge clock);
         n++;
      end
      if (!bus.dataRdy_I2C) begin
         checks++; errors++;
         $display("FAIL rdy_timeout: no dataRdy_I2C within %0d cycles", 200 * CD);
      end
   endtask

   task automatic run_txn(input logic [6:0] addr, input logic mode, input logic [7:0] wbyte,
                          input logic ack_a, input logic ack_d, input logic [7:0] rdata);
      issue(addr, mode, wbyte, ack_a, ack_d, rdata);
      wait_rdy();
      @(negedge clock);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Stimulus
   initial begin
      bus.start_I2C = 1'b0; bus.mode_I2C = 1'b0; bus.sensorAddr_I2C = 7'd0; bus.writeVal_I2C = 8'd0;
      repeat (3) @(negedge clock);
      check("rst_scl_oe", bus.scl_oe, 0);
      check("rst_sda_oe", bus.sda_oe, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_dataRdy", bus.dataRdy_I2C, 0);
      check("rst_ack_err", bus.ack_err, 0);
      check("rst_readVal", bus.readVal_I2C, 0);
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         check("idle_bus", {bus.scl_oe, bus.sda_oe, bus.busy}, 0);
      end

      // directed transactions
      run_txn(7'h48, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00);
      run_txn(7'h48, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C);
      run_txn(7'h48, 1'b1, 8'h00, 1'b0, 1'b1, 8'h77);
      run_txn(7'h21, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00);

      // randomized transactions
      for (int i = 0; i < 16; i++) begin
         run_txn(7'($urandom), 1'($urandom), 8'($urandom),
                 $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0, 8'($urandom));
      end

      // overlap: pulses mid-transfer and in DONE are ignored
      issue(7'h33, 1'b1, 8'h00, 1'b1, 1'b1, 8'hC3);
      repeat (100) @(negedge clock);
      bus.start_I2C = 1'b1; bus.mode_I2C = 1'b0; bus.sensorAddr_I2C = 7'h11;
      @(negedge clock);
      bus.start_I2C = 1'b0;
      wait_rdy();
      bus.start_I2C = 1'b1;
      @(negedge clock);
      check("done_pulse_ignored", bus.busy, 0);
      issue(7'h0F, 1'b0, 8'h96, 1'b1, 1'b1, 8'h00);
      check("start_q0_busy", bus.busy, 1);
      check("start_q0_bus", {bus.scl_oe, bus.sda_oe}, 0);
      wait_rdy();
      @(negedge clock);

      // reset during address bit 5
      issue(7'h5B, 1'b0, 8'hE1, 1'b1, 1'b1, 8'h00);
      repeat (3 * 4 * CD + CD + 1) @(negedge clock);
      check("scl_low_before_rst", bus.scl_oe, 1);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_scl_oe", bus.scl_oe, 0);
      check("rst_mid_sda_oe", bus.sda_oe, 0);
      void'(sb.pop_back());
      exp_rdval = 8'h00;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("rst_mid_no_rdy", bus.dataRdy_I2C, 0);
      end
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         check("post_rst_quiet", {bus.dataRdy_I2C, bus.busy, bus.scl_oe, bus.sda_oe}, 0);
      end
      run_txn(7'h5B, 1'b0, 8'hE1, 1'b1, 1'b1, 8'h00);
      run_txn(7'h6C, 1'b1, 8'h00, 1'b1, 1'b1, 8'h81);

      repeat (5) @(negedge clock);
      if (sb.size() != 0) begin
         checks++; errors++;
         $display("FAIL leftover_expected: %0d transactions never completed", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
